// File: rtl/control_sm.sv
// Moore main control FSM for the multicycle CPU: fetch/decode/execute/memory/writeback sequencing.
// Define CTRL_HALT_EN to build the HALT state (OP_HALT stops the machine until reset).
module control_sm #(
    parameter logic [5:0] OP_LW   = 6'h3B,
    parameter logic [5:0] OP_SW   = 6'h3C,
    parameter logic [5:0] OP_BEQ  = 6'h3D,
    parameter logic [5:0] OP_JMP  = 6'h3E,
    parameter logic [5:0] OP_HALT = 6'h3F
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP_Code,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       PC_Reg_Write,
    output logic       PC_Reg_Write_BEQ,
    output logic       Instruction_Reg_Write,
    output logic       Memory_Data_Reg_Write,
    output logic       A_Reg_Write,
    output logic       B_Reg_Write,
    output logic       ALU_Op_Reg_Write,
    output logic       Register_File_Write,
    output logic       IorD_Mux_Select,
    output logic       Write_Data_Mux_Select,
    output logic       ALU_A_Mux_Select,
    output logic [1:0] ALU_B_Mux_Select,
    output logic [1:0] PC_Source_Mux_Select
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXEC_R    = 4'd2;
    localparam logic [3:0] S_EXEC_I    = 4'd3;
    localparam logic [3:0] S_ALU_WB    = 4'd4;
    localparam logic [3:0] S_MEM_ADDR  = 4'd5;
    localparam logic [3:0] S_MEM_READ  = 4'd6;
    localparam logic [3:0] S_MEM_WB    = 4'd7;
    localparam logic [3:0] S_MEM_WRITE = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
`ifdef CTRL_HALT_EN
    localparam logic [3:0] S_HALT      = 4'd11;
`endif

    logic [3:0] state;
    logic [3:0] state_next;
    logic       is_r_op;
    logic       is_i_op;

    assign is_r_op = (OP_Code[5] == 1'b0);
    assign is_i_op = (OP_Code[5:4] == 2'b10);

    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values;
    // reset is synchronous and overrides any pending transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                if (is_r_op)                                 state_next = S_EXEC_R;
                else if (is_i_op)                            state_next = S_EXEC_I;
                else if (OP_Code == OP_LW || OP_Code == OP_SW) state_next = S_MEM_ADDR;
                else if (OP_Code == OP_BEQ)                  state_next = S_BRANCH;
                else if (OP_Code == OP_JMP)                  state_next = S_JUMP;
`ifdef CTRL_HALT_EN
                else if (OP_Code == OP_HALT)                 state_next = S_HALT;
`endif
                else                                         state_next = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: state_next = S_ALU_WB;
            // Opcode is sampled again here; anything other than LW/SW falls back to fetch.
            S_MEM_ADDR: begin
                if (OP_Code == OP_LW)      state_next = S_MEM_READ;
                else if (OP_Code == OP_SW) state_next = S_MEM_WRITE;
                else                       state_next = S_FETCH;
            end
            S_MEM_READ: state_next = S_MEM_WB;
`ifdef CTRL_HALT_EN
            S_HALT:     state_next = S_HALT;
`endif
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        MemRead               = 1'b0;
        MemWrite              = 1'b0;
        PC_Reg_Write          = 1'b0;
        PC_Reg_Write_BEQ      = 1'b0;
        Instruction_Reg_Write = 1'b0;
        Memory_Data_Reg_Write = 1'b0;
        A_Reg_Write           = 1'b0;
        B_Reg_Write           = 1'b0;
        ALU_Op_Reg_Write      = 1'b0;
        Register_File_Write   = 1'b0;
        IorD_Mux_Select       = 1'b0;
        Write_Data_Mux_Select = 1'b0;
        ALU_A_Mux_Select      = 1'b0;
        ALU_B_Mux_Select      = 2'b00;
        PC_Source_Mux_Select  = 2'b00;
        case (state)
            S_FETCH: begin
                MemRead               = 1'b1;
                Instruction_Reg_Write = 1'b1;
                ALU_B_Mux_Select      = 2'b01;
                PC_Reg_Write          = 1'b1;
            end
            S_DECODE: begin
                A_Reg_Write      = 1'b1;
                B_Reg_Write      = 1'b1;
                ALU_B_Mux_Select = 2'b11;
                ALU_Op_Reg_Write = 1'b1;
            end
            S_EXEC_R: begin
                ALU_A_Mux_Select = 1'b1;
                ALU_Op_Reg_Write = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ALU_A_Mux_Select = 1'b1;
                ALU_B_Mux_Select = 2'b10;
                ALU_Op_Reg_Write = 1'b1;
            end
            S_ALU_WB: Register_File_Write = 1'b1;
            S_MEM_READ: begin
                MemRead               = 1'b1;
                IorD_Mux_Select       = 1'b1;
                Memory_Data_Reg_Write = 1'b1;
            end
            S_MEM_WB: begin
                Register_File_Write   = 1'b1;
                Write_Data_Mux_Select = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite        = 1'b1;
                IorD_Mux_Select = 1'b1;
            end
            S_BRANCH: begin
                ALU_A_Mux_Select     = 1'b1;
                PC_Reg_Write_BEQ     = 1'b1;
                PC_Source_Mux_Select = 2'b01;
            end
            S_JUMP: begin
                PC_Reg_Write         = 1'b1;
                PC_Source_Mux_Select = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sm.sv
// Table-driven bench for control_sm; expected output words are hand-derived per state.
// Honours CTRL_HALT_EN the same way the design does.
module tb_control_sm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OP_Code;
    logic       MemRead, MemWrite, PC_Reg_Write, PC_Reg_Write_BEQ;
    logic       Instruction_Reg_Write, Memory_Data_Reg_Write, A_Reg_Write, B_Reg_Write;
    logic       ALU_Op_Reg_Write, Register_File_Write, IorD_Mux_Select, Write_Data_Mux_Select;
    logic       ALU_A_Mux_Select;
    logic [1:0] ALU_B_Mux_Select, PC_Source_Mux_Select;

    control_sm dut (
        .clk(clk), .reset(reset), .OP_Code(OP_Code),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .PC_Reg_Write(PC_Reg_Write), .PC_Reg_Write_BEQ(PC_Reg_Write_BEQ),
        .Instruction_Reg_Write(Instruction_Reg_Write),
        .Memory_Data_Reg_Write(Memory_Data_Reg_Write),
        .A_Reg_Write(A_Reg_Write), .B_Reg_Write(B_Reg_Write),
        .ALU_Op_Reg_Write(ALU_Op_Reg_Write), .Register_File_Write(Register_File_Write),
        .IorD_Mux_Select(IorD_Mux_Select), .Write_Data_Mux_Select(Write_Data_Mux_Select),
        .ALU_A_Mux_Select(ALU_A_Mux_Select), .ALU_B_Mux_Select(ALU_B_Mux_Select),
        .PC_Source_Mux_Select(PC_Source_Mux_Select)
    );

    always #5 clk = ~clk;

    // Bit order: MemRead MemWrite PCW PCW_BEQ IRW MDRW A B ALUOutW RFW IorD WD ALU_A ALU_B[2] PC_Src[2]
    localparam logic [16:0] E_FETCH = 17'b1_0_1_0_1_0_0_0_0_0_0_0_0_01_00;
    localparam logic [16:0] E_DEC   = 17'b0_0_0_0_0_0_1_1_1_0_0_0_0_11_00;
    localparam logic [16:0] E_EXR   = 17'b0_0_0_0_0_0_0_0_1_0_0_0_1_00_00;
    localparam logic [16:0] E_EXI   = 17'b0_0_0_0_0_0_0_0_1_0_0_0_1_10_00;
    localparam logic [16:0] E_AWB   = 17'b0_0_0_0_0_0_0_0_0_1_0_0_0_00_00;
    localparam logic [16:0] E_MADR  = E_EXI;
    localparam logic [16:0] E_MRD   = 17'b1_0_0_0_0_1_0_0_0_0_1_0_0_00_00;
    localparam logic [16:0] E_MWB   = 17'b0_0_0_0_0_0_0_0_0_1_0_1_0_00_00;
    localparam logic [16:0] E_MWR   = 17'b0_1_0_0_0_0_0_0_0_0_1_0_0_00_00;
    localparam logic [16:0] E_BR    = 17'b0_0_0_1_0_0_0_0_0_0_0_0_1_00_01;
    localparam logic [16:0] E_JMP   = 17'b0_0_1_0_0_0_0_0_0_0_0_0_0_00_10;
    localparam logic [16:0] E_ZERO  = 17'b0;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [16:0] exp;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [16:0] outs();
        return {MemRead, MemWrite, PC_Reg_Write, PC_Reg_Write_BEQ, Instruction_Reg_Write,
                Memory_Data_Reg_Write, A_Reg_Write, B_Reg_Write, ALU_Op_Reg_Write,
                Register_File_Write, IorD_Mux_Select, Write_Data_Mux_Select,
                ALU_A_Mux_Select, ALU_B_Mux_Select, PC_Source_Mux_Select};
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] act;
        act = outs();
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive inputs mid-cycle, clock once, then sample 1 ns after the edge.
    task automatic step(input logic r, input logic [5:0] op, input logic [16:0] exp,
                        input string name);
        @(negedge clk);
        reset   = r;
        OP_Code = op;
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    vec_t tbl[$];

    initial begin
        reset   = 1'b1;
        OP_Code = 6'h00;

        tbl = '{
            '{1'b1, 6'h00, E_FETCH},
            // R op; opcode change during EXEC_R must be ignored
            '{1'b0, 6'h12, E_DEC},  '{1'b0, 6'h12, E_EXR},  '{1'b0, 6'h3B, E_AWB},
            '{1'b0, 6'h3B, E_FETCH},
            // LW held: repeats every 5 cycles
            '{1'b0, 6'h3B, E_DEC},  '{1'b0, 6'h3B, E_MADR}, '{1'b0, 6'h3B, E_MRD},
            '{1'b0, 6'h3B, E_MWB},  '{1'b0, 6'h3B, E_FETCH},
            '{1'b0, 6'h3B, E_DEC},  '{1'b0, 6'h3B, E_MADR}, '{1'b0, 6'h3B, E_MRD},
            '{1'b0, 6'h3B, E_MWB},  '{1'b0, 6'h3B, E_FETCH},
            // SW
            '{1'b0, 6'h3C, E_DEC},  '{1'b0, 6'h3C, E_MADR}, '{1'b0, 6'h3C, E_MWR},
            '{1'b0, 6'h3C, E_FETCH},
            // BEQ, JMP
            '{1'b0, 6'h3D, E_DEC},  '{1'b0, 6'h3D, E_BR},   '{1'b0, 6'h3D, E_FETCH},
            '{1'b0, 6'h3E, E_DEC},  '{1'b0, 6'h3E, E_JMP},  '{1'b0, 6'h3E, E_FETCH},
            // I op
            '{1'b0, 6'h25, E_DEC},  '{1'b0, 6'h25, E_EXI},  '{1'b0, 6'h00, E_AWB},
            '{1'b0, 6'h00, E_FETCH},
            // NOPs: 2-cycle loop
            '{1'b0, 6'h30, E_DEC},  '{1'b0, 6'h30, E_FETCH},
            '{1'b0, 6'h3A, E_DEC},  '{1'b0, 6'h3A, E_FETCH},
            // LW decoded, SW seen in MEM_ADDR -> store
            '{1'b0, 6'h3B, E_DEC},  '{1'b0, 6'h3B, E_MADR}, '{1'b0, 6'h3C, E_MWR},
            '{1'b0, 6'h3C, E_FETCH},
            // class boundaries 0x1F (R), 0x20 and 0x2F (I)
            '{1'b0, 6'h1F, E_DEC},  '{1'b0, 6'h1F, E_EXR},  '{1'b0, 6'h1F, E_AWB},
            '{1'b0, 6'h20, E_FETCH},
            '{1'b0, 6'h20, E_DEC},  '{1'b0, 6'h20, E_EXI},  '{1'b0, 6'h20, E_AWB},
            '{1'b0, 6'h2F, E_FETCH},
            '{1'b0, 6'h2F, E_DEC},  '{1'b0, 6'h2F, E_EXI},  '{1'b0, 6'h2F, E_AWB},
            '{1'b0, 6'h2F, E_FETCH}
        };

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].op, tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Reset aborts a load in MEM_READ; no write enable survives
        step(1'b0, 6'h3B, E_DEC,   "abort_dec");
        step(1'b0, 6'h3B, E_MADR,  "abort_madr");
        step(1'b0, 6'h3B, E_MRD,   "abort_mrd");
        step(1'b1, 6'h3B, E_FETCH, "abort_reset");
        step(1'b0, 6'h3B, E_DEC,   "abort_resume");
        step(1'b1, 6'h3B, E_FETCH, "reset_in_decode");

        // Halt opcode
        step(1'b0, 6'h3F, E_DEC, "halt_dec");
`ifdef CTRL_HALT_EN
        step(1'b0, 6'h3F, E_ZERO, "halt_enter");
        step(1'b0, 6'h12, E_ZERO, "halt_hold1");
        step(1'b0, 6'h3B, E_ZERO, "halt_hold2");
        step(1'b0, 6'h00, E_ZERO, "halt_hold3");
        step(1'b1, 6'h00, E_FETCH, "halt_reset");
        step(1'b0, 6'h00, E_DEC,   "halt_after");
`else
        step(1'b0, 6'h3F, E_FETCH, "halt_as_nop");
        step(1'b0, 6'h3F, E_DEC,   "halt_as_nop_dec");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_sm.md
Name: control_sm

Overview:
- Moore-style main control FSM for the team's multicycle 32-bit CPU datapath.
- Sequences fetch, decode, execute, memory and writeback steps per instruction.
- Drives all register write enables, memory strobes and mux selects from the current state and the 6-bit opcode held in the instruction register.
- Sits beside the datapath; OP_Code comes from the instruction register output.

Parameters:
- OP_LW, 6'h3B, load-word opcode
- OP_SW, 6'h3C, store-word opcode
- OP_BEQ, 6'h3D, branch-if-equal opcode
- OP_JMP, 6'h3E, jump opcode
- OP_HALT, 6'h3F, halt opcode (see Optional Feature)

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high reset
- OP_Code  in  6  current instruction opcode from the instruction register
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- PC_Reg_Write  out  1  unconditional PC load
- PC_Reg_Write_BEQ  out  1  PC load qualified by datapath zero flag
- Instruction_Reg_Write  out  1  instruction register load
- Memory_Data_Reg_Write  out  1  memory data register load
- A_Reg_Write  out  1  register A load
- B_Reg_Write  out  1  register B load
- ALU_Op_Reg_Write  out  1  ALU output register load
- Register_File_Write  out  1  register file write enable
- IorD_Mux_Select  out  1  memory address select: 0 = PC, 1 = ALU output register
- Write_Data_Mux_Select  out  1  register file write data: 0 = ALU output register, 1 = memory data register
- ALU_A_Mux_Select  out  1  ALU A input: 0 = PC, 1 = A
- ALU_B_Mux_Select  out  2  ALU B input: 00 = B, 01 = constant 1, 10 = sign-extended immediate, 11 = branch offset
- PC_Source_Mux_Select  out  2  PC source: 00 = ALU result, 01 = ALU output register, 10 = jump target

Behaviour:
- Encoding and reset
  - 4-bit state register; outputs are pure decode of state (Moore).
  - Any output not listed for a state is 0.
  - reset high at a rising edge puts the next state at FETCH, so after reset the outputs show FETCH values.
  - Reset has priority over any transition and aborts mid-instruction; no write enable of the aborted state persists.
- Opcode classes, decoded in DECODE only
  - 6'h00–6'h1F: register ALU op (R).
  - 6'h20–6'h2F: immediate ALU op (I).
  - OP_LW, OP_SW, OP_BEQ, OP_JMP as named.
  - All other values: NOP.
- States, outputs and next state:
  - FETCH: MemRead=1, IorD=0, Instruction_Reg_Write=1, ALU_A=0, ALU_B=01, PC_Source=00, PC_Reg_Write=1 -> DECODE.
  - DECODE: A_Reg_Write=1, B_Reg_Write=1, ALU_A=0, ALU_B=11, ALU_Op_Reg_Write=1. Next: R->EXEC_R, I->EXEC_I, LW/SW->MEM_ADDR, BEQ->BRANCH, JMP->JUMP, NOP->FETCH.
  - EXEC_R: ALU_A=1, ALU_B=00, ALU_Op_Reg_Write=1 -> ALU_WB.
  - EXEC_I: ALU_A=1, ALU_B=10, ALU_Op_Reg_Write=1 -> ALU_WB.
  - ALU_WB: Register_File_Write=1, Write_Data=0 -> FETCH.
  - MEM_ADDR: ALU_A=1, ALU_B=10, ALU_Op_Reg_Write=1 -> MEM_READ if LW, MEM_WRITE if SW (OP_Code re-read here).
  - MEM_READ: MemRead=1, IorD=1, Memory_Data_Reg_Write=1 -> MEM_WB.
  - MEM_WB: Register_File_Write=1, Write_Data=1 -> FETCH.
  - MEM_WRITE: MemWrite=1, IorD=1 -> FETCH.
  - BRANCH: ALU_A=1, ALU_B=00, PC_Reg_Write_BEQ=1, PC_Source=01 -> FETCH.
  - JUMP: PC_Reg_Write=1, PC_Source=10 -> FETCH.
  - HALT: all outputs 0; stays in HALT until reset.
  - Unused encodings -> FETCH, outputs 0.
- Cycle counts, FETCH to FETCH: R/I 4, LW 5, SW 4, BEQ 3, JMP 3, NOP 2.
- OP_Code changes outside DECODE and MEM_ADDR are ignored.

Optional Feature:
- CTRL_HALT_EN defined: OP_HALT in DECODE -> HALT state; exit only via reset.
- Undefined: OP_HALT decodes as NOP (DECODE -> FETCH); HALT state not built.

Test Plan:
- Reset pulse, OP_Code=0 -> FETCH outputs next cycle: MemRead=1, Instruction_Reg_Write=1, PC_Reg_Write=1, ALU_B=01, all others 0.
- OP_Code=6'h12 after reset -> FETCH, DECODE, EXEC_R (ALU_A=1, ALU_B=00), ALU_WB (Register_File_Write=1, Write_Data=0), FETCH.
- OP_Code=6'h3B -> FETCH, DECODE, MEM_ADDR (ALU_B=10), MEM_READ (MemRead=1, IorD=1), MEM_WB (Register_File_Write=1, Write_Data=1); repeats every 5 cycles while held.
- OP_Code=6'h3C -> MEM_ADDR then MEM_WRITE (MemWrite=1, IorD=1, Register_File_Write=0); 4-cycle loop.
- OP_Code=6'h3D / 6'h3E -> BRANCH (PC_Reg_Write_BEQ=1, PC_Source=01) / JUMP (PC_Reg_Write=1, PC_Source=10); 3-cycle loop.
- Reset asserted in MEM_READ -> FETCH next cycle. With CTRL_HALT_EN, OP_Code=6'h3F -> all outputs 0 and held until reset.
